gray_frame_sink: RTL and testbench

Avalon-ST grayscale frame receiver sitting downstream of the 3×3 convolution filter: accepts the filtered pixel stream, checks SOP/EOP framing against the configured frame size, and writes pixels into a ping-pong frame buffer. A completed frame is committed by swapping banks, so the display/readback side always reads a whole, consistent frame. Malformed packets are discarded and counted.

---
 rtl/gray_stream_pkg.sv | 28 ++
 rtl/gray_frame_sink_if.sv | 31 +++
 rtl/gray_frame_bank.sv | 67 ++++++
 rtl/gray_frame_sink.sv | 226 ++++++++++++++++++++++
 tb/tb_gray_frame_sink.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_stream_pkg.sv
// -----------------------------------------------------------------------------
// gray_stream_pkg
// Shared types for the grayscale frame sink.
//   pixel_t       8-bit grayscale sample
//   err_cnt_t     saturating error counter word (ERR_CNT_W bits)
//   sink_state_t  receive FSM states: IDLE, RECV, FLUSH, SWAP
//   sat_inc()     increment that holds at all-ones instead of wrapping
// -----------------------------------------------------------------------------
package gray_stream_pkg;

  localparam int PIXEL_W   = 8;
  localparam int ERR_CNT_W = 16;

  typedef logic [PIXEL_W-1:0]   pixel_t;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLUSH,
    SWAP
  } sink_state_t;

  function automatic err_cnt_t sat_inc(input err_cnt_t cnt, input logic inc);
    return (inc && (cnt != '1)) ? cnt + err_cnt_t'(1) : cnt;
  endfunction

endpackage

// File: rtl/gray_frame_sink_if.sv
// -----------------------------------------------------------------------------
// gray_frame_sink_if
// Avalon-ST pixel stream between the convolution filter (master) and the
// frame sink (slave).
//   data_in           pixel, master -> slave
//   startofpacket_in  first pixel of a frame, master -> slave
//   endofpacket_in    last pixel of a frame, master -> slave
//   valid_in          beat valid, master -> slave
//   ready_out         sink can accept a beat, slave -> master
// A beat transfers on a rising edge where valid_in && ready_out.
// -----------------------------------------------------------------------------
interface gray_frame_sink_if;
  import gray_stream_pkg::*;

  pixel_t data_in;
  logic   startofpacket_in;
  logic   endofpacket_in;
  logic   valid_in;
  logic   ready_out;

  modport master (
    output data_in, startofpacket_in, endofpacket_in, valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in, startofpacket_in, endofpacket_in, valid_in,
    output ready_out
  );

endinterface

// File: rtl/gray_frame_bank.sv
// -----------------------------------------------------------------------------
// gray_frame_bank
// Ping-pong frame store: two banks of N pixels in one simple dual-port RAM.
//   clk, reset   clock; synchronous active-high reset (read register only)
//   we           write enable
//   wr_bank      bank selected for the write
//   wr_addr      pixel index within the bank, raster order
//   wr_data      pixel to store
//   rd_bank      bank selected for the read
//   rd_addr      pixel index within the bank, raster order
//   rd_data      registered read data, one cycle after rd_bank/rd_addr
// Addresses beyond N-1 on the read side return 0.
// -----------------------------------------------------------------------------
module gray_frame_bank
  import gray_stream_pkg::*;
#(
  parameter int N  = 36,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  pixel_t        wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output pixel_t        rd_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  // NOTE: the array has no reset so it maps onto block RAM; frame contents
  // are only meaningful once a whole frame has been committed into a bank.
  pixel_t mem [2][N];

  pixel_t rd_data_d;
  pixel_t rd_data_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs, independent of process order.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data_d = '0;
    if (rd_addr <= LAST_IDX) begin
      rd_data_d = mem[rd_bank][rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gray_frame_sink.sv
// -----------------------------------------------------------------------------
// gray_frame_sink
// Receives the filtered Avalon-ST grayscale stream, checks SOP/EOP framing
// against WIDTH x HEIGHT, and fills the back bank of a ping-pong frame
// buffer. A correctly framed packet is committed by swapping banks once the
// reader is not mid-frame, so the reader always sees a whole frame.
// Malformed packets are discarded and reported.
//
// Parameters: WIDTH, HEIGHT  frame size in pixels (N = WIDTH*HEIGHT)
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   s               stream slave (data/SOP/EOP/valid in, ready out)
//   rd_addr         read index into the front bank, raster order
//   rd_data         registered read data (1-cycle latency)
//   rd_busy         reader mid-frame; holds a pending bank swap
//   front_bank      bank currently exposed to the reader
//   frame_done      one-cycle pulse on bank swap
//   err_pulse       one-cycle pulse the cycle after any framing error
//   err_no_sop      beats dropped in IDLE for lacking SOP (saturating)
//   err_framing     short frames and restarts by early SOP (saturating)
//   err_long        frames exceeding N pixels (saturating)
// Build option: define GRAY_FRAME_SINK_ERR_CNT_EN to implement the three
// error counters; otherwise they read as 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module gray_frame_sink
  import gray_stream_pkg::*;
#(
  parameter  int WIDTH  = 6,
  parameter  int HEIGHT = 6,
  localparam int N      = WIDTH * HEIGHT,
  localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  gray_frame_sink_if.slave     s,
  input  logic [AW-1:0]        rd_addr,
  output pixel_t               rd_data,
  input  logic                 rd_busy,
  output logic                 front_bank,
  output logic                 frame_done,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_no_sop,
  output logic [ERR_CNT_W-1:0] err_framing,
  output logic [ERR_CNT_W-1:0] err_long
);

  localparam logic [AW-1:0] LAST_IDX   = AW'(N - 1);
  localparam bit            SINGLE_PIX = (N == 1);

  sink_state_t   state_q, state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic          front_bank_q, front_bank_d;
  logic          frame_done_q, frame_done_d;
  logic          err_pulse_q, err_pulse_d;

  logic          accept;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic          swap;
  logic          ev_no_sop;
  logic          ev_framing;
  logic          ev_long;

  // Ready depends on state alone; reset masks it so nothing is accepted
  // while reset is held, even though the state register is already IDLE.
  assign s.ready_out = !reset && (state_q != SWAP);
  assign accept      = s.valid_in && s.ready_out;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    we         = 1'b0;
    wr_addr    = wr_idx_q;
    swap       = 1'b0;
    ev_no_sop  = 1'b0;
    ev_framing = 1'b0;
    ev_long    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!s.startofpacket_in) begin
            ev_no_sop = 1'b1;
          end else begin
            we       = 1'b1;
            wr_addr  = '0;
            wr_idx_d = AW'(1);
            if (SINGLE_PIX) begin
              // One-pixel frames are complete on the SOP beat itself.
              wr_idx_d = '0;
              if (s.endofpacket_in) begin
                state_d = SWAP;
              end else begin
                ev_long = 1'b1;
                state_d = FLUSH;
              end
            end else if (s.endofpacket_in) begin
              ev_framing = 1'b1;
              wr_idx_d   = '0;
            end else begin
              state_d = RECV;
            end
          end
        end
      end

      RECV: begin
        if (accept) begin
          we = 1'b1;
          if (s.startofpacket_in) begin
            // A fresh SOP abandons the partial frame and restarts at pixel 0.
            ev_framing = 1'b1;
            wr_addr    = '0;
            wr_idx_d   = AW'(1);
          end else if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            if (s.endofpacket_in) begin
              state_d = SWAP;
            end else begin
              ev_long = 1'b1;
              state_d = FLUSH;
            end
          end else if (s.endofpacket_in) begin
            ev_framing = 1'b1;
            wr_idx_d   = '0;
            state_d    = IDLE;
          end else begin
            wr_idx_d = wr_idx_q + AW'(1);
          end
        end
      end

      FLUSH: begin
        // Overlong packet: drop everything up to and including its EOP.
        if (accept && s.endofpacket_in) begin
          state_d = IDLE;
        end
      end

      SWAP: begin
        if (!rd_busy) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    front_bank_d = front_bank_q ^ swap;
    frame_done_d = swap;
    err_pulse_d  = ev_no_sop || ev_framing || ev_long;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_idx_q     <= '0;
      front_bank_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      front_bank_q <= front_bank_d;
      frame_done_q <= frame_done_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  assign front_bank = front_bank_q;
  assign frame_done = frame_done_q;
  assign err_pulse  = err_pulse_q;

`ifdef GRAY_FRAME_SINK_ERR_CNT_EN
  err_cnt_t no_sop_cnt_q, no_sop_cnt_d;
  err_cnt_t framing_cnt_q, framing_cnt_d;
  err_cnt_t long_cnt_q, long_cnt_d;

  always_comb begin
    no_sop_cnt_d  = sat_inc(no_sop_cnt_q, ev_no_sop);
    framing_cnt_d = sat_inc(framing_cnt_q, ev_framing);
    long_cnt_d    = sat_inc(long_cnt_q, ev_long);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      no_sop_cnt_q  <= '0;
      framing_cnt_q <= '0;
      long_cnt_q    <= '0;
    end else begin
      no_sop_cnt_q  <= no_sop_cnt_d;
      framing_cnt_q <= framing_cnt_d;
      long_cnt_q    <= long_cnt_d;
    end
  end

  assign err_no_sop  = no_sop_cnt_q;
  assign err_framing = framing_cnt_q;
  assign err_long    = long_cnt_q;
`else
  assign err_no_sop  = '0;
  assign err_framing = '0;
  assign err_long    = '0;
`endif

  // Writes always target the back bank; reads always see the front bank as
  // registered, so a read issued in the swap cycle still returns old data.
  gray_frame_bank #(
    .N  (N),
    .AW (AW)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wr_bank (!front_bank_q),
    .wr_addr (wr_addr),
    .wr_data (s.data_in),
    .rd_bank (front_bank_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_gray_frame_sink.sv
// -----------------------------------------------------------------------------
// tb_gray_frame_sink
// Directed bench for gray_frame_sink with a 6x6 frame. Inputs change on the
// falling edge; outputs are sampled on the falling edge. Counter expectations
// follow GRAY_FRAME_SINK_ERR_CNT_EN (0 when the counters are not built).
// -----------------------------------------------------------------------------
module tb_gray_frame_sink;
  import gray_stream_pkg::*;

  localparam int WIDTH  = 6;
  localparam int HEIGHT = 6;
  localparam int N      = WIDTH * HEIGHT;

`ifdef GRAY_FRAME_SINK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [5:0]  rd_addr = '0;
  logic        rd_busy = 1'b0;
  pixel_t      rd_data;
  logic        front_bank;
  logic        frame_done;
  logic        err_pulse;
  logic [15:0] err_no_sop;
  logic [15:0] err_framing;
  logic [15:0] err_long;

  gray_frame_sink_if u_if ();

  gray_frame_sink #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s           (u_if.slave),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .front_bank  (front_bank),
    .frame_done  (frame_done),
    .err_pulse   (err_pulse),
    .err_no_sop  (err_no_sop),
    .err_framing (err_framing),
    .err_long    (err_long)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse tallies, sampled shortly after each rising edge.
  int ep_cnt = 0;
  int fd_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (err_pulse === 1'b1) ep_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  int exp_no_sop  = 0;
  int exp_framing = 0;
  int exp_long    = 0;

  // ---------------------------------------------------------------- helpers
  task automatic beat(input pixel_t d, input logic sop, input logic eop);
    u_if.data_in          = d;
    u_if.startofpacket_in = sop;
    u_if.endofpacket_in   = eop;
    u_if.valid_in         = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_stream();
    u_if.valid_in         = 1'b0;
    u_if.startofpacket_in = 1'b0;
    u_if.endofpacket_in   = 1'b0;
  endtask

  task automatic idle(input int n);
    stop_stream();
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input int addr, output pixel_t v);
    rd_addr = 6'(addr);
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic send_clean(input pixel_t base);
    for (int i = 0; i < N; i++) beat(base + 8'(i), i == 0, i == N - 1);
    stop_stream();
  endtask

  // Counts ready_out-low cycles until frame_done is seen, bounded by budget.
  task automatic wait_swap(input int budget, output int low, output bit seen);
    low  = 0;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (frame_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (u_if.ready_out === 1'b0) low++;
        @(negedge clk);
      end
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (u_if.ready_out !== 1'b0) $display("FAIL reset_ready: got %b exp 0", u_if.ready_out); else n_pass++;
    n_checks++; if (front_bank !== 1'b0) $display("FAIL reset_front_bank: got %b exp 0", front_bank); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b exp 0", frame_done); else n_pass++;
    n_checks++; if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse: got %b exp 0", err_pulse); else n_pass++;
    n_checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h exp 00", rd_data); else n_pass++;
    n_checks++; if ({err_no_sop, err_framing, err_long} !== 48'h0) $display("FAIL reset_counters: got %h/%h/%h exp 0/0/0", err_no_sop, err_framing, err_long); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (u_if.ready_out !== 1'b1) $display("FAIL reset_release_ready: got %b exp 1", u_if.ready_out); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_clean_frame();
    int low; bit seen; int fd0; pixel_t v;
    fd0 = fd_cnt;
    send_clean(8'd0);
    wait_swap(20, low, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL clean_frame_done: got %b exp 1", seen); else n_pass++;
    n_checks++; if (low != 1) $display("FAIL clean_ready_low_cycles: got %0d exp 1", low); else n_pass++;
    n_checks++; if (front_bank !== 1'b1) $display("FAIL clean_front_bank: got %b exp 1", front_bank); else n_pass++;
    n_checks++; if (u_if.ready_out !== 1'b1) $display("FAIL clean_ready_after: got %b exp 1", u_if.ready_out); else n_pass++;
    @(negedge clk);
    n_checks++; if (fd_cnt - fd0 != 1) $display("FAIL clean_done_pulses: got %0d exp 1", fd_cnt - fd0); else n_pass++;
    rd(5, v);
    n_checks++; if (v !== 8'd5) $display("FAIL clean_rd5: got %h exp 05", v); else n_pass++;
    rd(35, v);
    n_checks++; if (v !== 8'd35) $display("FAIL clean_rd35: got %h exp 23", v); else n_pass++;
  endtask

  task automatic test_backpressure();
    int low; int fd0; int fb_bad; pixel_t v;
    low = 0; fb_bad = 0;
    fd0 = fd_cnt;
    rd_busy = 1'b1;
    send_clean(8'd100);
    for (int i = 0; i < 10; i++) begin
      if (u_if.ready_out === 1'b0) low++;
      if (front_bank !== 1'b1) fb_bad++;
      if (i == 9) begin
        rd_busy = 1'b0;
        rd_addr = 6'd7;   // read issued in the swap cycle
      end
      @(negedge clk);
    end
    n_checks++; if (low != 10) $display("FAIL bp_ready_low_cycles: got %0d exp 10", low); else n_pass++;
    n_checks++; if (fb_bad != 0) $display("FAIL bp_early_swap: got %0d exp 0", fb_bad); else n_pass++;
    n_checks++; if (frame_done !== 1'b1) $display("FAIL bp_frame_done: got %b exp 1", frame_done); else n_pass++;
    n_checks++; if (front_bank !== 1'b0) $display("FAIL bp_front_bank: got %b exp 0", front_bank); else n_pass++;
    n_checks++; if (rd_data !== 8'd7) $display("FAIL bp_swap_cycle_read: got %h exp 07", rd_data); else n_pass++;
    n_checks++; if (fd_cnt - fd0 != 1) $display("FAIL bp_done_pulses: got %0d exp 1", fd_cnt - fd0); else n_pass++;
    rd(7, v);
    n_checks++; if (v !== 8'd107) $display("FAIL bp_rd7: got %h exp 6b", v); else n_pass++;
  endtask

  task automatic test_short_frame();
    int ep0; int fd0; pixel_t v;
    ep0 = ep_cnt; fd0 = fd_cnt;
    for (int i = 0; i <= 20; i++) beat(8'd50 + 8'(i), i == 0, i == 20);
    idle(4);
    exp_framing++;
    n_checks++; if (ep_cnt - ep0 != 1) $display("FAIL short_err_pulses: got %0d exp 1", ep_cnt - ep0); else n_pass++;
    n_checks++; if (fd_cnt - fd0 != 0) $display("FAIL short_no_commit: got %0d exp 0", fd_cnt - fd0); else n_pass++;
    n_checks++; if (front_bank !== 1'b0) $display("FAIL short_front_bank: got %b exp 0", front_bank); else n_pass++;
    n_checks++; if (err_framing !== (CNT_EN ? 16'(exp_framing) : 16'd0)) $display("FAIL short_err_framing: got %0d exp %0d", err_framing, CNT_EN ? exp_framing : 0); else n_pass++;
    n_checks++; if (u_if.ready_out !== 1'b1) $display("FAIL short_ready: got %b exp 1", u_if.ready_out); else n_pass++;
    rd(3, v);
    n_checks++; if (v !== 8'd103) $display("FAIL short_front_intact: got %h exp 67", v); else n_pass++;
  endtask

  task automatic test_early_sop();
    int ep0; int low; bit seen; pixel_t v;
    ep0 = ep_cnt;
    for (int i = 0; i < 10; i++) beat(8'h30 + 8'(i), i == 0, 1'b0);
    beat(8'hAA, 1'b1, 1'b0);
    for (int k = 1; k < N; k++) beat(8'h40 + 8'(k), 1'b0, k == N - 1);
    stop_stream();
    exp_framing++;
    wait_swap(20, low, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL early_sop_commit: got %b exp 1", seen); else n_pass++;
    n_checks++; if (low != 1) $display("FAIL early_sop_ready_low: got %0d exp 1", low); else n_pass++;
    n_checks++; if (front_bank !== 1'b1) $display("FAIL early_sop_front_bank: got %b exp 1", front_bank); else n_pass++;
    n_checks++; if (ep_cnt - ep0 != 1) $display("FAIL early_sop_err_pulses: got %0d exp 1", ep_cnt - ep0); else n_pass++;
    n_checks++; if (err_framing !== (CNT_EN ? 16'(exp_framing) : 16'd0)) $display("FAIL early_sop_err_framing: got %0d exp %0d", err_framing, CNT_EN ? exp_framing : 0); else n_pass++;
    rd(0, v);
    n_checks++; if (v !== 8'hAA) $display("FAIL early_sop_rd0: got %h exp aa", v); else n_pass++;
    rd(1, v);
    n_checks++; if (v !== 8'h41) $display("FAIL early_sop_rd1: got %h exp 41", v); else n_pass++;
    rd(35, v);
    n_checks++; if (v !== 8'h63) $display("FAIL early_sop_rd35: got %h exp 63", v); else n_pass++;
  endtask

  task automatic test_junk_long();
    int ep0; int fd0;
    ep0 = ep_cnt; fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) beat(8'hEE, 1'b0, 1'b0);
    idle(2);
    exp_no_sop += 3;
    n_checks++; if (ep_cnt - ep0 != 3) $display("FAIL junk_err_pulses: got %0d exp 3", ep_cnt - ep0); else n_pass++;
    n_checks++; if (err_no_sop !== (CNT_EN ? 16'(exp_no_sop) : 16'd0)) $display("FAIL junk_err_no_sop: got %0d exp %0d", err_no_sop, CNT_EN ? exp_no_sop : 0); else n_pass++;
    // 40-beat packet; SOP on beat 37 (0-based) must be ignored while flushing.
    ep0 = ep_cnt;
    for (int i = 0; i < 40; i++) beat(8'h80 + 8'(i), i == 0 || i == 37, i == 39);
    idle(4);
    exp_long++;
    n_checks++; if (ep_cnt - ep0 != 1) $display("FAIL long_err_pulses: got %0d exp 1", ep_cnt - ep0); else n_pass++;
    n_checks++; if (fd_cnt - fd0 != 0) $display("FAIL long_no_commit: got %0d exp 0", fd_cnt - fd0); else n_pass++;
    n_checks++; if (front_bank !== 1'b1) $display("FAIL long_front_bank: got %b exp 1", front_bank); else n_pass++;
    n_checks++; if (err_long !== (CNT_EN ? 16'(exp_long) : 16'd0)) $display("FAIL long_err_long: got %0d exp %0d", err_long, CNT_EN ? exp_long : 0); else n_pass++;
    n_checks++; if (err_framing !== (CNT_EN ? 16'(exp_framing) : 16'd0)) $display("FAIL long_err_framing: got %0d exp %0d", err_framing, CNT_EN ? exp_framing : 0); else n_pass++;
    // Back in IDLE: a beat without SOP must be flagged again.
    ep0 = ep_cnt;
    beat(8'h11, 1'b0, 1'b0);
    idle(2);
    exp_no_sop++;
    n_checks++; if (ep_cnt - ep0 != 1) $display("FAIL long_back_to_idle: got %0d exp 1", ep_cnt - ep0); else n_pass++;
    n_checks++; if (err_no_sop !== (CNT_EN ? 16'(exp_no_sop) : 16'd0)) $display("FAIL long_err_no_sop: got %0d exp %0d", err_no_sop, CNT_EN ? exp_no_sop : 0); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int ep0; int low; bit seen; pixel_t v;
    for (int i = 0; i < 15; i++) beat(8'hC0 + 8'(i), i == 0, 1'b0);
    stop_stream();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (u_if.ready_out !== 1'b0) $display("FAIL midrst_ready_in_reset: got %b exp 0", u_if.ready_out); else n_pass++;
    reset = 1'b0;
    exp_no_sop = 0; exp_framing = 0; exp_long = 0;
    #1;
    n_checks++; if (u_if.ready_out !== 1'b1) $display("FAIL midrst_ready: got %b exp 1", u_if.ready_out); else n_pass++;
    n_checks++; if (front_bank !== 1'b0) $display("FAIL midrst_front_bank: got %b exp 0", front_bank); else n_pass++;
    n_checks++; if ({err_no_sop, err_framing, err_long} !== 48'h0) $display("FAIL midrst_counters: got %h/%h/%h exp 0/0/0", err_no_sop, err_framing, err_long); else n_pass++;
    n_checks++; if (err_pulse !== 1'b0) $display("FAIL midrst_err_pulse: got %b exp 0", err_pulse); else n_pass++;
    @(negedge clk);
    ep0 = ep_cnt;
    send_clean(8'h20);
    wait_swap(20, low, seen);
    n_checks++; if (seen !== 1'b1) $display("FAIL midrst_commit: got %b exp 1", seen); else n_pass++;
    n_checks++; if (low != 1) $display("FAIL midrst_ready_low: got %0d exp 1", low); else n_pass++;
    n_checks++; if (front_bank !== 1'b1) $display("FAIL midrst_front_after: got %b exp 1", front_bank); else n_pass++;
    n_checks++; if (ep_cnt - ep0 != 0) $display("FAIL midrst_clean_no_err: got %0d exp 0", ep_cnt - ep0); else n_pass++;
    rd(14, v);
    n_checks++; if (v !== 8'h2E) $display("FAIL midrst_rd14: got %h exp 2e", v); else n_pass++;
    rd(0, v);
    n_checks++; if (v !== 8'h20) $display("FAIL midrst_rd0: got %h exp 20", v); else n_pass++;
  endtask

  initial begin
    stop_stream();
    u_if.data_in = '0;
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_short_frame();
    test_early_sop();
    test_junk_long();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks done", n_pass, n_checks);
    $fatal(1);
  end

endmodule
